dmem_access_unit: RTL

//  Parametrised successor of the word-only data-memory wrapper: owns a byte-enabled synchronous RAM and

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_ram_be.sv | 24 ++
 rtl/dmem_access_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-enabled data-memory access unit.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  // Half uses only addr_lo[1] and word ignores addr_lo, so misaligned low bits are aligned implicitly.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = '0;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] addr_lo, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    r = '0;
    case (size)
      SZ_B:    r = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    r = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      SZ_W:    r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// DEPTH_WORDS x 32 synchronous-read RAM with per-byte write enables.
module dmem_ram_be #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS),
  parameter              INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             re,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store unit over a byte-enabled RAM: one request per two cycles, registered response with error flag.
// Optional feature: define DMEM_MISALIGN_EXC_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter              INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        accept, misalign, err_now;
  logic [3:0]  wr_be;
  logic [31:0] wr_data, ram_rdata;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q, lo_q;
  logic [ADDR_W-IDX_W-3:0] unused_addr_hi;

  assign unused_addr_hi = req_addr[ADDR_W-1:IDX_W+2];
  assign req_ready      = (state_q == ST_IDLE);
  assign accept         = req_valid && req_ready;

`ifdef DMEM_MISALIGN_EXC_EN
  assign misalign = ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err_now = (req_size == SZ_RSV) || misalign;
  assign wr_be   = (accept && req_we && !err_now) ? byte_en(req_size, req_addr[1:0]) : '0;

  always_comb begin
    wr_data = req_wdata;
    case (req_size)
      SZ_B:    wr_data = {4{req_wdata[7:0]}};
      SZ_H:    wr_data = {2{req_wdata[15:0]}};
      default: wr_data = req_wdata;
    endcase
  end

  dmem_ram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .re   (accept && !req_we),
    .be   (wr_be),
    .idx  (req_addr[IDX_W+1:2]),
    .wdata(wr_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= SZ_B;
      lo_q   <= '0;
    end else if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      err_q  <= err_now;
      size_q <= req_size;
      lo_q   <= req_addr[1:0];
    end
  end

  // Response is combinational from state so an async reset during RESP drops it immediately.
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_extend(ram_rdata, size_q, lo_q, uns_q) : '0;

endmodule
